// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer and MIPS field decode.
// The fetch-side ready is a pure state decode, so it has no combinational path from downstream.
module if_id_skid_reg #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int IMM_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_opcode,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_funct,
    output logic [IMM_W-1:0]   out_imm,
    output logic [25:0]        out_target,
    output logic [PC_W-1:0]    out_pc_plus4,
    output logic               out_is_rtype,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef struct packed {
        logic [5:0]       opcode;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        logic [IMM_W-1:0] imm;
        logic [25:0]      target;
        logic [PC_W-1:0]  pc_plus4;
        logic             is_rtype;
    } if_id_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    if_id_t           main_q, main_d;
    if_id_t           skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    if_id_t           dec;
    logic             accept;
    logic             consume;

    function automatic if_id_t decode(
        input logic [INSTR_W-1:0] instr,
        input logic [PC_W-1:0]    pc
    );
        if_id_t d;
        d.opcode   = instr[31:26];
        d.rs       = instr[25:21];
        d.rt       = instr[20:16];
        d.rd       = instr[15:11];
        d.shamt    = instr[10:6];
        d.funct    = instr[5:0];
        d.imm      = instr[IMM_W-1:0];
        d.target   = instr[25:0];
        d.pc_plus4 = pc + PC_W'(4);
        d.is_rtype = (instr[31:26] == 6'h00);
        return d;
    endfunction

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign dec       = decode(in_instr, in_pc);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = TWO;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Saturating count of cycles where decode holds off a valid entry.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign out_opcode   = main_q.opcode;
    assign out_rs       = main_q.rs;
    assign out_rt       = main_q.rt;
    assign out_rd       = main_q.rd;
    assign out_shamt    = main_q.shamt;
    assign out_funct    = main_q.funct;
    assign out_imm      = main_q.imm;
    assign out_target   = main_q.target;
    assign out_pc_plus4 = main_q.pc_plus4;
    assign out_is_rtype = main_q.is_rtype;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: scenario tasks plus a FIFO scoreboard
// that checks every consumed entry against the instruction/PC that was accepted.
module tb_if_id_skid_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [15:0] out_imm;
    logic [25:0] out_target;
    logic [31:0] out_pc_plus4;
    logic        out_is_rtype;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } txn_t;

    txn_t sb[$];
    txn_t mon_t;
    logic [106:0] mon_got;
    logic [106:0] mon_exp;

    if_id_skid_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_shamt    (out_shamt),
        .out_funct    (out_funct),
        .out_imm      (out_imm),
        .out_target   (out_target),
        .out_pc_plus4 (out_pc_plus4),
        .out_is_rtype (out_is_rtype),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [106:0] model(input txn_t t);
        logic [31:0] pc4;
        pc4 = t.pc + 32'd4;
        return {t.instr[31:26], t.instr[25:21], t.instr[20:16],
                t.instr[15:11], t.instr[10:6], t.instr[5:0],
                t.instr[15:0], t.instr[25:0], pc4,
                (t.instr[31:26] == 6'd0)};
    endfunction

    // Handshakes are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got opcode %h pc4 %h, required no output",
                             out_opcode, out_pc_plus4);
                end else begin
                    mon_t   = sb.pop_front();
                    mon_exp = model(mon_t);
                    mon_got = {out_opcode, out_rs, out_rt, out_rd, out_shamt,
                               out_funct, out_imm, out_target, out_pc_plus4,
                               out_is_rtype};
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_fields: got %h required %h", mon_got, mon_exp);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back({in_instr, in_pc});
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_stall_cnt: got %h required 0", stall_cnt);
        end
        checks++;
        if ({out_opcode, out_target, out_pc_plus4, out_is_rtype} !== 65'd0) begin
            errors++; $display("FAIL rst_fields: got %h %h %h %b required 0",
                               out_opcode, out_target, out_pc_plus4, out_is_rtype);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_itype();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h2008FFFC;
        in_pc     = 32'h00400000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL itype_valid: got %b required 1", out_valid);
        end
        checks++;
        if ({out_opcode, out_rs, out_rt, out_imm} !== {6'h08, 5'd0, 5'd8, 16'hFFFC}) begin
            errors++; $display("FAIL itype_fields: got %h %h %h %h required 08 00 08 fffc",
                               out_opcode, out_rs, out_rt, out_imm);
        end
        checks++;
        if (out_pc_plus4 !== 32'h00400004 || out_is_rtype !== 1'b0) begin
            errors++; $display("FAIL itype_pc4: got %h rtype %b required 00400004 rtype 0",
                               out_pc_plus4, out_is_rtype);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL itype_drain: got %b required 0", out_valid);
        end
    endtask

    task automatic test_rtype();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h012A4020;
        in_pc     = 32'h00400010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_is_rtype}
            !== {6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 1'b1}) begin
            errors++; $display("FAIL rtype_fields: got %h %h %h %h %h %h %b required 00 09 0a 08 00 20 1",
                               out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_is_rtype);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c;
        logic [15:0] s0;
        a = 32'h8D090010;
        b = 32'h01095020;
        c = 32'hAD0A0008;
        @(posedge clk); #1;
        s0        = stall_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = a;
        in_pc     = 32'h00001000;
        @(posedge clk); #1;
        in_instr = b;
        in_pc    = 32'h00001004;
        @(posedge clk); #1;
        in_instr = c;
        in_pc    = 32'h00001008;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== s0 + 16'd4) begin
            errors++; $display("FAIL bp_stall_cnt: got %0d required %0d", stall_cnt, s0 + 16'd4);
        end
        checks++;
        if (out_opcode !== a[31:26] || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_head: got opcode %h ready %b required %h ready 0",
                               out_opcode, in_ready, a[31:26]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: got %0d pending valid %b required 0 pending valid 0",
                               sb.size(), out_valid);
        end
        checks++;
        if (stall_cnt !== s0 + 16'd4) begin
            errors++; $display("FAIL bp_stall_hold: got %0d required %0d", stall_cnt, s0 + 16'd4);
        end
    endtask

    task automatic test_flush_two();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h24420001;
        in_pc     = 32'h00002000;
        @(posedge clk); #1;
        in_instr = 32'h24630002;
        in_pc    = 32'h00002004;
        @(posedge clk); #1;
        flush    = 1'b1;
        in_instr = 32'h24840003;
        in_pc    = 32'h00002008;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got valid %b ready %b required valid 0 ready 1",
                               out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++; $display("FAIL flush_leak: got valid %b pending %0d required valid 0 pending 0",
                               out_valid, sb.size());
        end
    endtask

    task automatic test_pc_wrap();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h3C01ABCD;
        in_pc     = 32'hFFFFFFFC;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc_plus4 !== 32'h00000000) begin
            errors++; $display("FAIL pc_wrap: got valid %b pc4 %h required valid 1 pc4 00000000",
                               out_valid, out_pc_plus4);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00851020;
        in_pc     = 32'h00003000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_reach: got %h required ffff", stall_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h required ffff", stall_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || stall_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_drain: got pending %0d cnt %h required 0 ffff",
                               sb.size(), stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h8C430000;
        in_pc     = 32'h00004000;
        @(posedge clk); #1;
        in_instr = 32'h8C640004;
        in_pc    = 32'h00004004;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'd5 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL ar_setup: got cnt %0d ready %b valid %b required 5 0 1",
                               stall_cnt, in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL ar_async: got valid %b cnt %0d required valid 0 cnt 0",
                               out_valid, stall_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL ar_after: got ready %b valid %b required ready 1 valid 0",
                               in_ready, out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;
        test_reset();
        test_single_itype();
        test_rtype();
        test_backpressure();
        test_flush_two();
        test_pc_wrap();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
Pipeline register between instruction fetch and decode. Accepts a 32-bit MIPS instruction and its PC through a valid/ready handshake, and splits it into decode fields. The imm field drives the 16->32 sign extender directly. A 2-entry skid buffer keeps the fetch-side ready signal registered and free of combinational paths. The block also provides a synchronous flush for branches and jumps, plus a saturating stall counter for performance monitoring.

Parameters:
INSTR_W, 32, instruction width; fixed MIPS encoding, other values unsupported
PC_W, 32, PC width
IMM_W, 16, immediate field width; equals the sign extender input width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all held and incoming instructions
in_valid  in  1  fetch presents instruction
in_ready  out  1  block can accept an instruction
in_instr  in  INSTR_W  instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  decode fields valid
out_ready  in  1  decode consumes this cycle
out_opcode  out  6  instr[31:26]
out_rs  out  5  instr[25:21]
out_rt  out  5  instr[20:16]
out_rd  out  5  instr[15:11]
out_shamt  out  5  instr[10:6]
out_funct  out  6  instr[5:0]
out_imm  out  IMM_W  instr[15:0], unextended; feeds the sign extender
out_target  out  26  instr[25:0]
out_pc_plus4  out  PC_W  in_pc + 4, modulo 2^PC_W
out_is_rtype  out  1  opcode == 6'h00
stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state EMPTY; out_valid=0; every field output=0; stall_cnt=0; in_ready=1.
- Storage: main register drives the outputs directly; skid register is internal only.
- States:
  - EMPTY: no entry held.
  - ONE: main valid.
  - TWO: main and skid valid.
- in_ready = (state != TWO). It is a registered-state decode and never depends on out_ready or in_valid.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready; out_valid = (state != EMPTY).
- Transitions (flush=0):
  - EMPTY + accept -> ONE. Main loads the input. Latency 1 cycle from accept to out_valid.
  - ONE + accept & consume -> ONE. Main reloads with the new input.
  - ONE + accept & !consume -> TWO. Skid loads the input.
  - ONE + consume & !accept -> EMPTY.
  - TWO + consume -> ONE. Skid moves to main. No accept is possible in TWO.
  - Any other combination holds the current state.
- Field decode: computed from the instruction at capture and stored in the register. out_pc_plus4 wraps: 0xFFFFFFFC -> 0x00000000.
- Flush (synchronous):
  - Next state is EMPTY and out_valid=0 next cycle.
  - An instruction accepted in the flush cycle is discarded.
  - A consume in the flush cycle still counts as consumed by downstream.
  - in_ready is 1 on the cycle after flush.
  - Field outputs hold their last values; they are don't-care while out_valid=0.
  - stall_cnt is unaffected by flush.
- Ordering: strict FIFO. No drop or duplication except on flush.
- Ready-before-valid is allowed on both sides. Downstream may deassert out_ready at any time. Upstream must hold in_instr/in_pc stable while in_valid=1 and in_ready=0; this cannot occur in ONE/EMPTY by design.
- stall_cnt: +1 per cycle where out_valid & !out_ready. Saturates at 2^CNT_W-1 and does not wrap. Cleared only by reset.
- Reset mid-operation clears both entries immediately. Contents are lost and out_valid drops asynchronously.

Test Plan:
- Single I-type: after reset, in_instr=0x2008FFFC, in_pc=0x00400000, out_ready=1 -> next cycle out_valid=1, opcode=0x08, rs=0, rt=8, imm=0xFFFC, pc_plus4=0x00400004, is_rtype=0. Following cycle out_valid=0.
- R-type decode: 0x012A4020 -> opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, is_rtype=1.
- Backpressure: out_ready=0; stream A,B,C with in_valid=1 -> A and B accepted, then in_ready=0 and C held. stall_cnt increments each stalled cycle. Release out_ready -> A,B,C emerge in order with no loss and no duplicate.
- Flush in TWO: hold A,B; assert flush with in_valid=1 and instruction C -> next cycle out_valid=0, in_ready=1, and A, B, C never appear.
- PC wrap: in_pc=0xFFFFFFFC -> out_pc_plus4=0x00000000. Counter saturation: force 70000 stall cycles -> stall_cnt=0xFFFF.
- Async reset while in TWO with stall_cnt=5 -> out_valid=0 and stall_cnt=0 without a clock edge, then in_ready=1.
